// File: rtl/pipeline_hazard_controller.sv
// Central hazard / stall sequencer for the 5-stage pipeline.
// Produces PC and pipeline-register write enables and flushes, arbitrates
// memory wait, taken branch, load-use and jump events, runs the data-memory
// req/ack handshake with a timeout, and counts stalled cycles.
module pipeline_hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_Jump,
  input  logic [4:0]       ex_rt,
  input  logic             ex_MemRead,
  input  logic             mem_BranchTaken,
  input  logic             mem_MemAccess,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use, mem_ack, mem_busy, frozen;
  logic pc_w, ifid_w, idex_w, exmem_w;
  logic ifid_f, idex_f, exmem_f, memwb_f, req;

  // Event detection: ack only counts while a memory access is actually pending.
  always_comb begin
    load_use = ex_MemRead && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    mem_ack  = mem_MemAccess && dmem_ack;
    mem_busy = (state_q == ST_MEM_WAIT) || ((state_q == ST_RUN) && mem_MemAccess);
    frozen   = mem_busy && !mem_ack;
  end

  // Prioritised control: memory freeze > taken branch > load-use > jump.
  always_comb begin
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    idex_w  = 1'b1;
    exmem_w = 1'b1;
    ifid_f  = 1'b0;
    idex_f  = 1'b0;
    exmem_f = 1'b0;
    memwb_f = 1'b0;
    req     = mem_busy;
    if (state_q == ST_ERROR) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_w  = 1'b0;
      exmem_w = 1'b0;
      req     = 1'b0;
    end else if (frozen) begin
      // Hold everything upstream of MEM; a bubble enters MEM/WB.
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_w  = 1'b0;
      exmem_w = 1'b0;
      memwb_f = 1'b1;
    end else if (mem_BranchTaken) begin
      ifid_f  = 1'b1;
      idex_f  = 1'b1;
      exmem_f = 1'b1;
    end else if (load_use) begin
      // The jump in ID (if any) is simply retried next cycle.
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_f  = 1'b1;
    end else if (id_Jump) begin
      ifid_f  = 1'b1;
    end
  end

  // Outputs are forced low while reset is held so no register advances.
  always_comb begin
    dmem_req     = reset & req;
    pc_write     = reset & pc_w;
    if_id_write  = reset & ifid_w;
    id_ex_write  = reset & idex_w;
    ex_mem_write = reset & exmem_w;
    if_id_flush  = reset & ifid_f;
    id_ex_flush  = reset & idex_f;
    ex_mem_flush = reset & exmem_f;
    mem_wb_flush = reset & memwb_f;
    mem_error    = reset & err_q;
    stall_count  = stall_cnt_q;
  end

  // Next-state: handshake sequencing, timeout and saturating stall counter.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (frozen) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          state_d = ST_RUN;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if ((wait_cnt_q + 8'd1) >= TIMEOUT_C) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      ST_ERROR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (!pc_w && (state_q != ST_ERROR) && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // State, wait counter, sticky error and stall counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with an event-level model
// checked every negative clock edge plus hand-computed literal checkpoints.
module tb_pipeline_hazard_controller;
  localparam int TO = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_Jump, ex_MemRead, mem_BranchTaken, mem_MemAccess, dmem_ack;
  logic dmem_req, pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_error;
  logic [CW-1:0] stall_count;

  int total = 0;
  int bad   = 0;

  pipeline_hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_Jump(id_Jump),
    .ex_rt(ex_rt), .ex_MemRead(ex_MemRead), .mem_BranchTaken(mem_BranchTaken),
    .mem_MemAccess(mem_MemAccess), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .mem_error(mem_error),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // waiting: a memory access is outstanding; errored: timed out.
  bit m_waiting = 0, m_errored = 0;
  int m_waited = 0, m_stalls = 0;
  bit n_waiting, n_errored;
  int n_waited, n_stalls;

  always @(negedge clk) begin
    bit e_req, e_pc, e_ifw, e_idw, e_exw, e_iff, e_idf, e_exf, e_mwf, e_err;
    bit pending, acked, stuck, lu;
    pending = m_waiting || mem_MemAccess;
    acked   = mem_MemAccess && dmem_ack;
    stuck   = pending && !acked;
    lu      = ex_MemRead && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
    {e_req, e_pc, e_ifw, e_idw, e_exw, e_iff, e_idf, e_exf, e_mwf, e_err} = '0;
    n_waiting = m_waiting; n_errored = m_errored; n_waited = m_waited; n_stalls = m_stalls;
    if (!reset) begin
      n_waiting = 0; n_errored = 0; n_waited = 0; n_stalls = 0;
    end else if (m_errored) begin
      e_err = 1;
    end else begin
      e_req = pending;
      if (stuck) begin
        e_mwf = 1;
        if (!m_waiting) begin n_waiting = 1; n_waited = 0; end
        else begin
          n_waited = m_waited + 1;
          if (n_waited == TO) n_errored = 1;
        end
      end else begin
        n_waiting = 0;
        {e_pc, e_ifw, e_idw, e_exw} = 4'b1111;
        if (mem_BranchTaken) {e_iff, e_idf, e_exf} = 3'b111;
        else if (lu) begin e_pc = 0; e_ifw = 0; e_idf = 1; end
        else if (id_Jump) e_iff = 1;
      end
      if (!e_pc && m_stalls < (1 << CW) - 1) n_stalls = m_stalls + 1;
    end
    check("dmem_req", dmem_req, e_req);
    check("pc_write", pc_write, e_pc);
    check("if_id_write", if_id_write, e_ifw);
    check("id_ex_write", id_ex_write, e_idw);
    check("ex_mem_write", ex_mem_write, e_exw);
    check("if_id_flush", if_id_flush, e_iff);
    check("id_ex_flush", id_ex_flush, e_idf);
    check("ex_mem_flush", ex_mem_flush, e_exf);
    check("mem_wb_flush", mem_wb_flush, e_mwf);
    check("mem_error", mem_error, e_err);
    check("stall_count", stall_count, reset ? m_stalls : 0);
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_waiting <= 0; m_errored <= 0; m_waited <= 0; m_stalls <= 0;
    end else begin
      m_waiting <= n_waiting; m_errored <= n_errored;
      m_waited <= n_waited;   m_stalls <= n_stalls;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rt = 0; id_Jump = 0; ex_MemRead = 0;
    mem_BranchTaken = 0; mem_MemAccess = 0; dmem_ack = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rnd_inputs();
    id_rs = 5'($urandom); id_rt = 5'($urandom); ex_rt = 5'($urandom);
    id_Jump = 1'($urandom); ex_MemRead = 1'($urandom); mem_BranchTaken = 1'($urandom);
    mem_MemAccess = 1'($urandom); dmem_ack = 1'($urandom);
  endtask

  initial begin
    reset = 0;
    idle();
    // Reset held with random inputs: everything low.
    for (int i = 0; i < 3; i++) begin
      tick(); rnd_inputs(); #1;
      check("rst_pc_write", pc_write, 0);
      check("rst_dmem_req", dmem_req, 0);
      check("rst_stall", stall_count, 0);
    end
    tick(); reset = 1; idle(); #1;
    check("rel_pc_write", pc_write, 1);
    check("rel_if_id_flush", if_id_flush, 0);
    // Load-use on rs.
    tick(); ex_MemRead = 1; ex_rt = 8; id_rs = 8; #1;
    check("lu_pc_write", pc_write, 0);
    check("lu_if_id_write", if_id_write, 0);
    check("lu_id_ex_flush", id_ex_flush, 1);
    tick(); idle(); #1;
    check("lu_stall", stall_count, 1);
    // r0 never creates a hazard.
    tick(); ex_MemRead = 1; ex_rt = 0; id_rs = 0; #1;
    check("r0_pc_write", pc_write, 1);
    // Branch beats load-use and jump.
    tick(); idle(); mem_BranchTaken = 1; ex_MemRead = 1; ex_rt = 8; id_rt = 8; id_Jump = 1; #1;
    check("br_stall", stall_count, 1);
    check("br_pc_write", pc_write, 1);
    check("br_if_id_flush", if_id_flush, 1);
    check("br_id_ex_flush", id_ex_flush, 1);
    check("br_ex_mem_flush", ex_mem_flush, 1);
    // Plain jump.
    tick(); idle(); id_Jump = 1; #1;
    check("j_pc_write", pc_write, 1);
    check("j_if_id_flush", if_id_flush, 1);
    check("j_id_ex_flush", id_ex_flush, 0);
    // Load-use on rt defers the jump.
    tick(); ex_MemRead = 1; ex_rt = 5; id_rt = 5; #1;
    check("luj_pc_write", pc_write, 0);
    check("luj_if_id_flush", if_id_flush, 0);
    tick(); idle(); #1;
    check("luj_stall", stall_count, 2);
    // Memory access acked on the 3rd cycle after req.
    tick(); mem_MemAccess = 1; #1;
    check("mw_dmem_req", dmem_req, 1);
    check("mw_mem_wb_flush", mem_wb_flush, 1);
    check("mw_ex_mem_write", ex_mem_write, 0);
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      check("mw_hold_pc_write", pc_write, 0);
      check("mw_hold_dmem_req", dmem_req, 1);
    end
    tick(); dmem_ack = 1; #1;
    check("mw_ack_pc_write", pc_write, 1);
    check("mw_ack_mem_wb_flush", mem_wb_flush, 0);
    check("mw_ack_dmem_req", dmem_req, 1);
    tick(); idle(); #1;
    check("mw_stall", stall_count, 5);
    // Zero-wait access, then a stray ack.
    tick(); mem_MemAccess = 1; dmem_ack = 1; #1;
    check("zw_pc_write", pc_write, 1);
    check("zw_dmem_req", dmem_req, 1);
    tick(); idle(); dmem_ack = 1; #1;
    check("stray_dmem_req", dmem_req, 0);
    check("stray_stall", stall_count, 5);
    // Ack cycle coinciding with a load-use hazard.
    tick(); idle(); mem_MemAccess = 1;
    tick(); dmem_ack = 1; ex_MemRead = 1; ex_rt = 3; id_rs = 3; #1;
    check("ackl_pc_write", pc_write, 0);
    check("ackl_id_ex_flush", id_ex_flush, 1);
    check("ackl_mem_wb_flush", mem_wb_flush, 0);
    tick(); idle(); #1;
    check("ackl_stall", stall_count, 7);
    // 20 load-use stalls saturate the 4-bit counter.
    tick(); ex_MemRead = 1; ex_rt = 9; id_rs = 9;
    repeat (19) tick();
    tick(); idle(); #1;
    check("sat_stall", stall_count, 15);
    // Timeout: never ack.
    #1 reset = 0; #1;
    check("rst2_stall", stall_count, 0);
    tick(); reset = 1; mem_MemAccess = 1;
    for (int i = 0; i < TO; i++) begin
      tick(); #1;
      check("to_wait_mem_error", mem_error, 0);
    end
    tick(); #1;
    check("to_mem_error", mem_error, 1);
    check("to_dmem_req", dmem_req, 0);
    check("to_pc_write", pc_write, 0);
    check("to_mem_wb_flush", mem_wb_flush, 0);
    check("to_stall", stall_count, 5);
    tick(); dmem_ack = 1; #1;
    check("to_sticky", mem_error, 1);
    check("to_stall_hold", stall_count, 5);
    #1 reset = 0; #1;
    check("to_rst_mem_error", mem_error, 0);
    // Reset in the middle of a wait drops the request at once.
    tick(); reset = 1; idle(); mem_MemAccess = 1;
    tick(); #1;
    check("ab_dmem_req", dmem_req, 1);
    #1 reset = 0; #1;
    check("ab_dmem_req_drop", dmem_req, 0);
    tick(); reset = 1; idle(); #1;
    check("ab_pc_write", pc_write, 1);
    check("ab_dmem_req_idle", dmem_req, 0);
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central sequencer for the 5-stage pipeline. It produces the write-enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken branches resolved in MEM, jumps decoded in ID, and multi-cycle data-memory accesses through a req/ack handshake with timeout. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- MEM_TIMEOUT, 15: max cycles in MEM_WAIT without dmem_ack before entering ERROR (1..255)
- CNT_W, 16: stall counter width

Ports:
- clk  in  1  system clock; state and counter update on rising edge
- reset  in  1  asynchronous, active-low reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_Jump  in  1  instruction in ID is a jump
- ex_rt  in  5  destination rt of instruction in EX
- ex_MemRead  in  1  instruction in EX is a load
- mem_BranchTaken  in  1  branch in MEM resolved taken (Zero/BranchEquals/BranchNotEquals already combined)
- mem_MemAccess  in  1  instruction in MEM reads or writes data memory
- dmem_ack  in  1  data memory completes current access this cycle
- dmem_req  out  1  data memory access request
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID write enable
- id_ex_write, ex_mem_write  out  1 each  register write enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load bubble (all fields 0)
- mem_error  out  1  sticky memory-timeout error
- stall_count  out  CNT_W  saturating count of stalled cycles

## Operation
- States: RUN, MEM_WAIT, ERROR. All control outputs are combinational from the state and the inputs.
- Default in RUN with no event: all write enables = 1, all flushes = 0, dmem_req = 0.
- Event priority, highest first: memory access, then taken branch, then load-use, then jump.
- Memory access (RUN, mem_MemAccess = 1):
  - dmem_req = 1.
  - If dmem_ack = 1 in the same cycle, the access has zero wait and the other rules apply unchanged.
  - Otherwise: pc_write, if_id_write, id_ex_write and ex_mem_write = 0; mem_wb_flush = 1; no other flush; next state MEM_WAIT; wait counter cleared.
- MEM_WAIT:
  - dmem_req = 1.
  - Without ack: same freeze as above, wait counter +1.
  - With ack: freeze released that cycle and branch/load-use/jump rules apply; next state RUN.
  - Counter reaching MEM_TIMEOUT without ack: next state ERROR.
- ERROR: all write enables 0, all flushes 0, dmem_req = 0, mem_error = 1. Exited only by reset.
- Taken branch (mem_BranchTaken = 1, pipe not frozen): pc_write = 1 (PC takes the branch target); if_id_flush, id_ex_flush and ex_mem_flush = 1. Suppresses load-use and jump handling that cycle.
- Load-use hazard:
  - Condition: ex_MemRead = 1, ex_rt ≠ 0, and ex_rt equals id_rs or id_rt.
  - Response: pc_write = 0, if_id_write = 0, id_ex_flush = 1.
  - The jump is not honoured that cycle; it is re-evaluated next cycle.
- Jump (id_Jump = 1, no higher event): if_id_flush = 1, pc_write = 1.
- stall_count: +1 on every rising edge where pc_write = 0 and state ≠ ERROR. Saturates at all-ones.

## Timing
- Asserting reset: state goes to RUN, wait counter and stall_count go to 0, mem_error goes to 0, immediately and asynchronously.
- While reset is low, all outputs are 0, including write enables, so no register advances.
- Reset released: outputs follow RUN rules combinationally in the same cycle.
- Hazard and flush response latency is 0 cycles (combinational). Control takes effect at the next capture edge of the pipeline registers.
- A load-use stall lasts exactly 1 cycle: the load moves to MEM and the condition clears.
- A memory access with ack arriving on cycle k after req (k ≥ 1) freezes the pipe for k cycles.
- Timeout: mem_error rises on the edge that completes MEM_TIMEOUT consecutive unacknowledged MEM_WAIT cycles.
- dmem_ack outside MEM_WAIT, or with mem_MemAccess = 0, is ignored.
- Reset mid-MEM_WAIT aborts the access; dmem_req drops immediately.

## Test plan
- Reset: hold reset = 0 with random inputs → all outputs 0, stall_count = 0. Release → pc_write = 1, all flushes 0.
- Load-use: ex_MemRead = 1, ex_rt = 8, id_rs = 8 → one cycle of pc_write = 0, if_id_write = 0, id_ex_flush = 1; stall_count = 1. Repeat with ex_rt = 0 → no stall.
- Branch vs hazards: mem_BranchTaken = 1 with a load-use condition and id_Jump = 1 → pc_write = 1; if_id/id_ex/ex_mem_flush = 1; no stall.
- Memory wait: mem_MemAccess = 1, ack on the 3rd cycle → 3 cycles frozen with mem_wb_flush = 1, dmem_req = 1; release on the ack cycle; stall_count = 3.
- Timeout: MEM_TIMEOUT = 4, never ack → mem_error = 1 after 4 wait cycles. Stays sticky and frozen with dmem_req = 0 until reset.
- Saturation: CNT_W = 4, 20 load-use stalls → stall_count holds at 15.
